// File: rtl/stack_ctrl_arb.sv
// Round-robin arbiter and sequencer for a 4-entry bidirectional shift-register stack.
// Grants one op every two cycles, tracks occupancy, returns popped bits and flags misuse.
module stack_ctrl_arb #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_a,
  input  logic             op_a,
  input  logic             din_a,
  output logic             gnt_a,
  input  logic             req_b,
  input  logic             op_b,
  input  logic             din_b,
  output logic             gnt_b,
  input  logic             sr_top,
  output logic             sr_enb,
  output logic             sr_dir,
  output logic             sr_in,
  output logic             dout,
  output logic             dout_vld,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             ovf_err,
  output logic             unf_err,
  input  logic             err_clr
);

  typedef enum logic {IDLE = 1'b0, EXEC = 1'b1} state_e;

  state_e           state_q, state_d;
  logic             rr_last_q, rr_last_d;  // 0 = A served last, 1 = B served last
  logic             gnt_a_q, gnt_a_d, gnt_b_q, gnt_b_d;
  logic             sr_enb_q, sr_enb_d, sr_dir_q, sr_dir_d, sr_in_q, sr_in_d;
  logic             dout_q, dout_d, dout_vld_q, dout_vld_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic             full_c, empty_c, win_b_c, w_op_c, w_din_c;

  assign full_c  = (count_q == CNT_W'(DEPTH));
  assign empty_c = (count_q == '0);

  // B wins when alone, or on a tie when A was served last.
  assign win_b_c = req_b & (~req_a | ~rr_last_q);
  assign w_op_c  = win_b_c ? op_b  : op_a;
  assign w_din_c = win_b_c ? din_b : din_a;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_last_q  <= 1'b1;
      gnt_a_q    <= 1'b0;
      gnt_b_q    <= 1'b0;
      sr_enb_q   <= 1'b0;
      sr_dir_q   <= 1'b0;
      sr_in_q    <= 1'b0;
      dout_q     <= 1'b0;
      dout_vld_q <= 1'b0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_last_q  <= rr_last_d;
      gnt_a_q    <= gnt_a_d;
      gnt_b_q    <= gnt_b_d;
      sr_enb_q   <= sr_enb_d;
      sr_dir_q   <= sr_dir_d;
      sr_in_q    <= sr_in_d;
      dout_q     <= dout_d;
      dout_vld_q <= dout_vld_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_last_d  = rr_last_q;
    gnt_a_d    = 1'b0;
    gnt_b_d    = 1'b0;
    sr_enb_d   = 1'b0;
    sr_dir_d   = sr_dir_q;
    sr_in_d    = sr_in_q;
    dout_d     = dout_q;
    dout_vld_d = 1'b0;
    count_d    = count_q;
    // A new error in the same cycle as err_clr overrides the clear below.
    ovf_d      = ovf_q & ~err_clr;
    unf_d      = unf_q & ~err_clr;
    unique case (state_q)
      IDLE: begin
        if (req_a || req_b) begin
          state_d   = EXEC;
          rr_last_d = win_b_c;
          gnt_a_d   = ~win_b_c;
          gnt_b_d   = win_b_c;
          if (w_op_c) begin
            if (!full_c) begin
              sr_enb_d = 1'b1;
              sr_dir_d = 1'b1;
              sr_in_d  = w_din_c;
              count_d  = count_q + CNT_W'(1);
            end else begin
              ovf_d = 1'b1;
            end
          end else begin
            if (!empty_c) begin
              sr_enb_d = 1'b1;
              sr_dir_d = 1'b0;
              sr_in_d  = w_din_c;
              count_d  = count_q - CNT_W'(1);
            end else begin
              unf_d = 1'b1;
            end
          end
        end
      end
      EXEC: begin
        state_d = IDLE;
        // Capture the pre-shift top on the edge that performs the pop.
        if (sr_enb_q && !sr_dir_q) begin
          dout_d     = sr_top;
          dout_vld_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign gnt_a    = gnt_a_q;
  assign gnt_b    = gnt_b_q;
  assign sr_enb   = sr_enb_q;
  assign sr_dir   = sr_dir_q;
  assign sr_in    = sr_in_q;
  assign dout     = dout_q;
  assign dout_vld = dout_vld_q;
  assign count    = count_q;
  assign full     = full_c;
  assign empty    = empty_c;
  assign ovf_err  = ovf_q;
  assign unf_err  = unf_q;

endmodule

// File: tb/tb_stack_ctrl_arb.sv
// Scoreboard bench for stack_ctrl_arb with a behavioural 4-entry shift-register stack.
module tb_stack_ctrl_arb;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_a = 1'b0, op_a = 1'b0, din_a = 1'b0, gnt_a;
  logic       req_b = 1'b0, op_b = 1'b0, din_b = 1'b0, gnt_b;
  logic       sr_top, sr_enb, sr_dir, sr_in, dout, dout_vld;
  logic [2:0] count;
  logic       full, empty, ovf_err, unf_err;
  logic       err_clr = 1'b0;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       who;  // 0 = A, 1 = B
    logic       enb;
    logic       dir;
    logic       sin;
    logic [2:0] cnt;
  } gexp_t;

  gexp_t gq[$];
  logic  dq[$];

  stack_ctrl_arb #(.DEPTH(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .op_a(op_a), .din_a(din_a), .gnt_a(gnt_a),
    .req_b(req_b), .op_b(op_b), .din_b(din_b), .gnt_b(gnt_b),
    .sr_top(sr_top), .sr_enb(sr_enb), .sr_dir(sr_dir), .sr_in(sr_in),
    .dout(dout), .dout_vld(dout_vld), .count(count), .full(full), .empty(empty),
    .ovf_err(ovf_err), .unf_err(unf_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  // Environment: the shift-register stack, reset from the same rst.
  logic [3:0] stk;
  always @(posedge clk) begin
    if (rst) stk <= 4'b0;
    else if (sr_enb) stk <= sr_dir ? {stk[2:0], sr_in} : {1'b0, stk[3:1]};
  end
  assign sr_top = stk[0];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pop and compare whenever the DUT presents a grant or popped data.
  always @(negedge clk) begin
    gexp_t e;
    logic  d;
    if (gnt_a && gnt_b) chk("dual_grant", 32'(gnt_b), 32'(0));
    if (gnt_a || gnt_b) begin
      if (gq.size() == 0) chk("unexpected_grant", 32'(1), 32'(0));
      else begin
        e = gq.pop_front();
        chk("gnt_who", 32'(gnt_b), 32'(e.who));
        chk("gnt_sr_enb", 32'(sr_enb), 32'(e.enb));
        if (e.enb) begin
          chk("gnt_sr_dir", 32'(sr_dir), 32'(e.dir));
          if (e.dir) chk("gnt_sr_in", 32'(sr_in), 32'(e.sin));
        end
        chk("gnt_count", 32'(count), 32'(e.cnt));
      end
    end
    if (dout_vld) begin
      if (dq.size() == 0) chk("unexpected_dout_vld", 32'(1), 32'(0));
      else begin
        d = dq.pop_front();
        chk("dout", 32'(dout), 32'(d));
      end
    end
  end

  task automatic wait_gnt(input logic who, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((who ? gnt_b : gnt_a) === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("grant_timeout", 32'(0), 32'(1));
  endtask

  task automatic do_op(input logic who, input logic op, input logic din, input logic clr,
                       input logic exp_enb, input logic [2:0] exp_cnt,
                       input logic exp_vld, input logic exp_dout);
    logic ok;
    gq.push_back('{who: who, enb: exp_enb, dir: op, sin: din, cnt: exp_cnt});
    if (exp_vld) dq.push_back(exp_dout);
    if (who) begin req_b = 1'b1; op_b = op; din_b = din; end
    else     begin req_a = 1'b1; op_a = op; din_a = din; end
    err_clr = clr;
    wait_gnt(who, ok);
    if (who) req_b = 1'b0; else req_a = 1'b0;
    err_clr = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic ok;
    @(negedge clk);
    do_reset();
    chk("rst_count", 32'(count), 32'(0));
    chk("rst_empty", 32'(empty), 32'(1));
    chk("rst_full", 32'(full), 32'(0));
    chk("rst_gnt", 32'({gnt_a, gnt_b}), 32'(0));
    chk("rst_sr", 32'({sr_enb, sr_dir, sr_in}), 32'(0));
    chk("rst_dout", 32'({dout, dout_vld}), 32'(0));
    chk("rst_err", 32'({ovf_err, unf_err}), 32'(0));
    repeat (3) @(negedge clk);
    chk("idle_sr_enb", 32'(sr_enb), 32'(0));

    // A pushes 1,0,1,1 until full.
    do_op(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0);
    do_op(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0);
    do_op(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0);
    do_op(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0);
    chk("full_after_4", 32'(full), 32'(1));

    // Push while full: granted, no shift, overflow flagged.
    do_op(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd4, 1'b0, 1'b0);
    chk("ovf_set", 32'(ovf_err), 32'(1));
    chk("unf_quiet", 32'(unf_err), 32'(0));
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("ovf_clr", 32'(ovf_err), 32'(0));
    // Clear and new overflow on the same edge: set wins.
    do_op(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'd4, 1'b0, 1'b0);
    chk("ovf_set_wins", 32'(ovf_err), 32'(1));
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("ovf_clr2", 32'(ovf_err), 32'(0));

    // LIFO pops: 1,1,0,1.
    do_op(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 1'b1, 1'b1);
    do_op(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 1'b1, 1'b1);
    do_op(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b1, 1'b0);
    do_op(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    chk("empty_after_pops", 32'(empty), 32'(1));
    do_op(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    chk("unf_set", 32'(unf_err), 32'(1));
    repeat (2) @(negedge clk);
    chk("unf_sticky", 32'(unf_err), 32'(1));
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("unf_clr", 32'(unf_err), 32'(0));

    // Both held high after reset: A,B,A,B.
    do_reset();
    gq.push_back('{who: 1'b0, enb: 1'b1, dir: 1'b1, sin: 1'b1, cnt: 3'd1});
    gq.push_back('{who: 1'b1, enb: 1'b1, dir: 1'b1, sin: 1'b0, cnt: 3'd2});
    gq.push_back('{who: 1'b0, enb: 1'b1, dir: 1'b1, sin: 1'b0, cnt: 3'd3});
    gq.push_back('{who: 1'b1, enb: 1'b1, dir: 1'b1, sin: 1'b1, cnt: 3'd4});
    fork
      begin
        logic oka;
        for (int k = 0; k < 2; k++) begin
          req_a = 1'b1; op_a = 1'b1; din_a = (k == 0);
          wait_gnt(1'b0, oka);
        end
        req_a = 1'b0;
      end
      begin
        logic okb;
        for (int k = 0; k < 2; k++) begin
          req_b = 1'b1; op_b = 1'b1; din_b = (k == 1);
          wait_gnt(1'b1, okb);
        end
        req_b = 1'b0;
      end
    join
    chk("rr_full", 32'(full), 32'(1));

    // Reset during an EXEC pop: no data returned, occupancy cleared.
    gq.push_back('{who: 1'b0, enb: 1'b1, dir: 1'b0, sin: 1'b0, cnt: 3'd3});
    req_a = 1'b1; op_a = 1'b0; din_a = 1'b0;
    wait_gnt(1'b0, ok);
    req_a = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_count", 32'(count), 32'(0));
    chk("midrst_vld", 32'(dout_vld), 32'(0));
    chk("midrst_gnt_enb", 32'({gnt_a, gnt_b, sr_enb}), 32'(0));
    chk("midrst_empty", 32'(empty), 32'(1));
    @(negedge clk);
    chk("midrst_no_vld", 32'(dout_vld), 32'(0));
    do_op(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("post_rst_count", 32'(count), 32'(1));
    chk("gq_drained", 32'(gq.size()), 32'(0));
    chk("dq_drained", 32'(dq.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stack_ctrl_arb.md
Name: stack_ctrl_arb

Overview:
- Controller and 2-requester round-robin arbiter for the 4-entry bidirectional shift-register stack.
- Sequences one shift per granted request and tracks occupancy (count, full, empty).
- Returns popped data with a valid pulse and flags illegal push/pop as sticky errors.
- Sits between two client engines and the stack. The stack's active-low reset is driven from ~rst at top level.

Parameters:
DEPTH, 4, stack entries; must match the shift register width.
CNT_W, 3, occupancy counter width; must equal clog2(DEPTH+1).

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
req_a  in  1  requester A request; held until gnt_a seen
op_a  in  1  A operation: 1=push, 0=pop
din_a  in  1  A push data bit
gnt_a  out  1  one-cycle grant pulse to A
req_b / op_b / din_b / gnt_b  same as A, for requester B
sr_top  in  1  stack top bit (most-recent entry) from shift register
sr_enb  out  1  shift enable to shift register
sr_dir  out  1  shift direction: 1=push, 0=pop
sr_in  out  1  serial data into shift register top
dout  out  1  last popped bit
dout_vld  out  1  one-cycle pulse, dout valid
count  out  CNT_W  current occupancy, 0..DEPTH
full  out  1  count==DEPTH
empty  out  1  count==0
ovf_err  out  1  sticky: push attempted while full
unf_err  out  1  sticky: pop attempted while empty
err_clr  in  1  clears ovf_err/unf_err

Behaviour:
- Reset: state=IDLE. gnt_a, gnt_b, sr_enb, sr_dir, sr_in, dout, dout_vld, count, ovf_err and unf_err all 0. empty=1, full=0. rr_last=B, so A wins the first tie.
- FSM has 2 states: IDLE and EXEC. Throughput is at most 1 op per 2 cycles.
- IDLE, no req: stay IDLE; all pulses 0.
- IDLE, any req: select a winner.
  - Only one requesting: that one.
  - Both requesting: the one not equal to rr_last.
  - At the clock edge: gnt_winner<=1, rr_last<=winner, state<=EXEC.
- Legal-op registers, loaded at the same edge when the winner's op is legal: sr_enb<=1, sr_dir<=op, sr_in<=din.
  - Push is legal when !full; count then increments.
  - Pop is legal when !empty; count then decrements.
- Illegal op (push&&full or pop&&empty):
  - Still granted, so the requester does not hang; sr_enb<=0 and count unchanged.
  - ovf_err or unf_err sets.
- EXEC lasts exactly 1 cycle:
  - gnt and sr_enb are high during EXEC; the shift register shifts on the edge ending EXEC.
  - A legal pop captures dout<=sr_top at that edge (pre-shift top) and dout_vld=1 in the following cycle.
  - Next state is IDLE; gnt, sr_enb and dout_vld clear after one cycle.
- Requester contract: drop req (or present a new request) by the edge ending EXEC. A req still high in IDLE is a new request.
- Pop data ordering is LIFO. After push 1, push 0, pop, pop → dout sequence is 0, then 1.
- count is registered; full and empty are decoded from the registered count. Arbitration in IDLE uses the count as updated by the previous op.
- Errors:
  - err_clr clears both sticky flags.
  - If err_clr and a new error occur in the same cycle, set wins.
  - Error flags never clear otherwise, except by rst.
- Reset mid-operation: rst asserted in EXEC wins. All outputs return to reset values next cycle, no dout_vld is issued, and count=0 (the shift register is reset in the same cycle).
- op_x and din_x are sampled only in the IDLE cycle in which x wins.

Test Plan:
- Reset then idle: rst=1 for 2 cycles → count=0, empty=1, full=0, all pulses 0; no req → sr_enb stays 0.
- A pushes 1,0,1,1 sequentially → gnt_a pulses 4 times, 2 cycles apart; count 1,2,3,4; full=1 after 4th; sr_in matches din_a each EXEC.
- From full, B pushes → gnt_b pulses, sr_enb=0, count stays 4, ovf_err=1. Then err_clr=1 → ovf_err=0.
- Pop 4 times from {1,0,1,1 pushed} → dout_vld pulses with dout=1,1,0,1; empty=1. A 5th pop → gnt pulse, no dout_vld, unf_err=1.
- req_a and req_b held high continuously, mixed push ops → grants alternate A,B,A,B starting with A after reset; no requester is granted twice in a row.
- rst asserted during an EXEC pop → next cycle count=0, dout_vld=0, state IDLE; a subsequent push works normally (count=1).
